vm_multi_timer: RTL and testbench

//   Parametrised multi-mode countdown timer for the vending machine controller.

---
 rtl/vm_multi_timer.sv | 141 ++++++++++++++
 tb/tb_vm_multi_timer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_multi_timer.sv
// Multi-mode countdown timer: per-mode load table, start/pause/abort, timeout pulse+flag.
// Define VM_TIMER_PRESCALE_EN to tick once every PRESCALE clocks instead of every clock.
module vm_multi_timer #(
  parameter int CNT_W = 8,
  parameter int MODE_W = 2,
  parameter int NUM_MODES = 3,
  parameter logic [NUM_MODES*CNT_W-1:0] T_TABLE = {8'd3, 8'd4, 8'd10},
  parameter int PRESCALE = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  input  logic              pause,
  input  logic              abort,
  output logic              busy,
  output logic [CNT_W-1:0]  remaining,
  output logic [MODE_W-1:0] active_mode,
  output logic              timeout_pulse,
  output logic              timeout_flag,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t state, state_d;

  logic              start_ok;
  logic              counting;
  logic              tick;
  logic              done;
  logic              busy_d;
  logic [CNT_W-1:0]  rem_d;
  logic [MODE_W-1:0] mode_d;
  logic              pulse_d;
  logic              flag_d;
  logic              err_d;

  function automatic logic [CNT_W-1:0] load_of(input logic [MODE_W-1:0] m);
    load_of = '0;
    for (int i = 0; i < NUM_MODES; i++)
      if (int'(m) == i) load_of = T_TABLE[i*CNT_W +: CNT_W];
  endfunction

  // An illegal start is not a start: the running count carries on.
  assign start_ok = start && (int'(mode) < NUM_MODES);
  assign counting = (state == RUN || state == PAUSED) && !pause;
  assign done = counting &&
                (remaining == '0 || (tick && remaining == CNT_W'(1)));

  // A zero or negative PRESCALE has no meaning; nothing to build for it.
  if (PRESCALE < 1) begin : g_prescale_range
  end

`ifdef VM_TIMER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt;

  assign tick = counting && ps_cnt == PS_LAST;

  always_ff @(posedge clk) begin
    if (rst || abort || start_ok) ps_cnt <= '0;
    else if (tick)                ps_cnt <= '0;
    else if (counting)            ps_cnt <= ps_cnt + PS_W'(1);
  end
`else
  assign tick = counting;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      remaining     <= '0;
      active_mode   <= '0;
      timeout_pulse <= 1'b0;
      timeout_flag  <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_d;
      busy          <= busy_d;
      remaining     <= rem_d;
      active_mode   <= mode_d;
      timeout_pulse <= pulse_d;
      timeout_flag  <= flag_d;
      err           <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    if (abort) begin
      state_d = IDLE;
    end else if (start_ok) begin
      state_d = RUN;
    end else begin
      unique case (state)
        RUN, PAUSED: begin
          if (pause)     state_d = PAUSED;
          else if (done) state_d = DONE;
          else           state_d = RUN;
        end
        default: state_d = state;
      endcase
    end
  end

  always_comb begin
    rem_d   = remaining;
    mode_d  = active_mode;
    flag_d  = timeout_flag;
    pulse_d = 1'b0;
    err_d   = 1'b0;
    if (abort) begin
      rem_d  = '0;
      flag_d = 1'b0;
    end else if (start_ok) begin
      rem_d  = load_of(mode);
      mode_d = mode;
      flag_d = 1'b0;
    end else begin
      err_d = start;
      if (done) begin
        rem_d   = '0;
        pulse_d = 1'b1;
        flag_d  = 1'b1;
      end else if (tick) begin
        rem_d = remaining - CNT_W'(1);
      end
    end
    busy_d = (state_d == RUN) || (state_d == PAUSED);
  end

endmodule

// File: tb/tb_vm_multi_timer.sv
// Bench for vm_multi_timer: directed scenarios plus random stimulus vs a reference model.
// With VM_TIMER_PRESCALE_EN defined only reset and the prescaled countdown are exercised.
module tb_vm_multi_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       busy;
  logic [7:0] remaining;
  logic [1:0] active_mode;
  logic       timeout_pulse;
  logic       timeout_flag;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  int loads[3] = '{10, 4, 3};
  bit m_active;
  bit m_flag;
  bit m_pulse;
  bit m_err;
  int m_rem;
  int m_mode;

  always #5 clk = ~clk;

  vm_multi_timer #(.PRESCALE(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .pause(pause),
    .abort(abort),
    .busy(busy),
    .remaining(remaining),
    .active_mode(active_mode),
    .timeout_pulse(timeout_pulse),
    .timeout_flag(timeout_flag),
    .err(err)
  );

  function automatic void model_reset();
    m_active = 0;
    m_flag = 0;
    m_pulse = 0;
    m_err = 0;
    m_rem = 0;
    m_mode = 0;
  endfunction

  function automatic void model_step(bit s, int md, bit p, bit a);
    m_pulse = 0;
    m_err = 0;
    if (a) begin
      m_active = 0;
      m_rem = 0;
      m_flag = 0;
    end else if (s && md < 3) begin
      m_rem = loads[md];
      m_mode = md;
      m_flag = 0;
      m_active = 1;
    end else begin
      if (s) m_err = 1;
      if (m_active && !p) begin
        if (m_rem <= 1) begin
          m_rem = 0;
          m_active = 0;
          m_pulse = 1;
          m_flag = 1;
        end else begin
          m_rem = m_rem - 1;
        end
      end
    end
  endfunction

  task automatic drive(input bit s, input int md, input bit p, input bit a);
    start = s;
    mode = 2'(md);
    pause = p;
    abort = a;
    @(posedge clk);
    #1;
    model_step(s, md, p, a);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pause = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(2);
    n_cmp++;
    if (busy !== 1'b0 || remaining !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_busy_rem got busy=%b rem=%0d want 0/0", busy, remaining);
    end
    n_cmp++;
    if (active_mode !== 2'd0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mode_err got mode=%0d err=%b want 0/0", active_mode, err);
    end
    n_cmp++;
    if (timeout_pulse !== 1'b0 || timeout_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_timeout got p=%b f=%b want 0/0", timeout_pulse, timeout_flag);
    end
  endtask

  task automatic test_countdown();
    drive(1, 0, 0, 0);
    n_cmp++;
    if (remaining !== 8'd10 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL cd_load got rem=%0d busy=%b want 10/1", remaining, busy);
    end
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 0, 0);
      n_cmp++;
      if (remaining !== 8'(10 - i) || timeout_pulse !== (i == 10)) begin
        n_bad++;
        $display("FAIL cd_step%0d got rem=%0d p=%b want %0d/%b",
                 i, remaining, timeout_pulse, 10 - i, i == 10);
      end
    end
    drive(0, 0, 0, 0);
    n_cmp++;
    if (timeout_pulse !== 1'b0 || timeout_flag !== 1'b1 || busy !== 1'b0 ||
        remaining !== 8'd0) begin
      n_bad++;
      $display("FAIL cd_after got p=%b f=%b busy=%b rem=%0d want 0/1/0/0",
               timeout_pulse, timeout_flag, busy, remaining);
    end
  endtask

  task automatic test_pause();
    int cyc;
    bit seen;
    drive(1, 1, 0, 0);
    n_cmp++;
    if (remaining !== 8'd4 || timeout_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL pz_load got rem=%0d f=%b want 4/0", remaining, timeout_flag);
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0);
      n_cmp++;
      if (remaining !== 8'd2 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL pz_hold%0d got rem=%0d busy=%b want 2/1", i, remaining, busy);
      end
    end
    cyc = 7;
    seen = 0;
    while (!seen && cyc < 30) begin
      drive(0, 0, 0, 0);
      cyc++;
      if (timeout_pulse === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen || cyc != 9) begin
      n_bad++;
      $display("FAIL pz_latency got seen=%b cycles=%0d want 1/9", seen, cyc);
    end
  endtask

  task automatic test_restart();
    drive(1, 2, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    n_cmp++;
    if (remaining !== 8'd1) begin
      n_bad++;
      $display("FAIL rs_pre got rem=%0d want 1", remaining);
    end
    drive(1, 0, 0, 0);
    n_cmp++;
    if (remaining !== 8'd10 || timeout_pulse !== 1'b0 || timeout_flag !== 1'b0 ||
        active_mode !== 2'd0) begin
      n_bad++;
      $display("FAIL rs_restart got rem=%0d p=%b f=%b mode=%0d want 10/0/0/0",
               remaining, timeout_pulse, timeout_flag, active_mode);
    end
    drive(0, 0, 0, 1);
  endtask

  task automatic test_illegal();
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 1);
    drive(1, 3, 0, 0);
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || remaining !== 8'd0 || active_mode !== 2'd1) begin
      n_bad++;
      $display("FAIL il_err got err=%b busy=%b rem=%0d mode=%0d want 1/0/0/1",
               err, busy, remaining, active_mode);
    end
    drive(0, 0, 0, 0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL il_width got err=%b want 0", err);
    end
  endtask

  task automatic test_abort_rst();
    bit any_pulse;
    drive(1, 0, 0, 0);
    repeat (5) drive(0, 0, 0, 0);
    n_cmp++;
    if (remaining !== 8'd5) begin
      n_bad++;
      $display("FAIL ab_pre got rem=%0d want 5", remaining);
    end
    drive(0, 0, 0, 1);
    n_cmp++;
    if (busy !== 1'b0 || remaining !== 8'd0 || timeout_pulse !== 1'b0 ||
        timeout_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL ab_abort got busy=%b rem=%0d p=%b f=%b want 0/0/0/0",
               busy, remaining, timeout_pulse, timeout_flag);
    end
    any_pulse = 0;
    repeat (12) begin
      drive(0, 0, 0, 0);
      if (timeout_pulse !== 1'b0) any_pulse = 1;
    end
    n_cmp++;
    if (any_pulse) begin
      n_bad++;
      $display("FAIL ab_nopulse got pulse=1 want 0");
    end
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 0);
    do_reset(1);
    n_cmp++;
    if (busy !== 1'b0 || remaining !== 8'd0 || active_mode !== 2'd0 ||
        timeout_pulse !== 1'b0 || timeout_flag !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL ab_rst got busy=%b rem=%0d mode=%0d p=%b f=%b e=%b want all 0",
               busy, remaining, active_mode, timeout_pulse, timeout_flag, err);
    end
  endtask

  task automatic test_random();
    bit p;
    p = 0;
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      bit s;
      bit a;
      int md;
      s = ($urandom_range(7) == 0);
      a = ($urandom_range(31) == 0);
      md = int'($urandom_range(3));
      if ($urandom_range(5) == 0) p = ~p;
      drive(s, md, p, a);
      n_cmp++;
      if (busy !== m_active || remaining !== 8'(m_rem) || active_mode !== 2'(m_mode) ||
          timeout_pulse !== m_pulse || timeout_flag !== m_flag || err !== m_err) begin
        n_bad++;
        $display("FAIL rnd%0d got b=%b r=%0d m=%0d p=%b f=%b e=%b want %b/%0d/%0d/%b/%b/%b",
                 i, busy, remaining, active_mode, timeout_pulse, timeout_flag, err,
                 m_active, m_rem, m_mode, m_pulse, m_flag, m_err);
      end
    end
  endtask

  task automatic test_prescale();
    do_reset(1);
    drive(1, 1, 0, 0);
    for (int c = 1; c <= 16; c++) begin
      drive(0, 0, 0, 0);
      n_cmp++;
      if (remaining !== 8'(4 - c / 4) || timeout_pulse !== (c == 16)) begin
        n_bad++;
        $display("FAIL ps_clk%0d got rem=%0d p=%b want %0d/%b",
                 c, remaining, timeout_pulse, 4 - c / 4, c == 16);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
`ifdef VM_TIMER_PRESCALE_EN
    test_prescale();
`else
    test_countdown();
    test_pause();
    test_restart();
    test_illegal();
    test_abort_rst();
    test_random();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
